// File: rtl/sseg_mux_driver_pkg.sv
// ---------------------------------------------------------------------------
// sseg_mux_driver_pkg
// Shared constants and types for the multiplexed seven-segment display
// driver. Imported by sseg_mux_driver and its hex2sseg decoder.
//
// Contents:
//   SSEG_BLANK  - segment pattern with every segment dark (active low)
//   PWM_LEVELS  - number of brightness steps a digit slot is divided into
//   out_mode_e  - whether the current scan slot drives its digit or stays dark
// ---------------------------------------------------------------------------
package sseg_mux_driver_pkg;

   localparam logic [6:0] SSEG_BLANK = 7'h7F;

   localparam int PWM_LEVELS = 16;

   typedef enum logic {
      OUT_DARK = 1'b0,
      OUT_LIT  = 1'b1
   } out_mode_e;

endpackage

// File: rtl/sseg_mux_driver_hex2sseg.sv
// ---------------------------------------------------------------------------
// hex2sseg
// Combinational hex digit to seven-segment decoder, active-low segments.
// Bit order of sseg is {g, f, e, d, c, b, a}; a 0 lights the segment.
//
// Ports:
//   hex   in  4  value 0..F to display
//   sseg  out 7  segment pattern, active low
// ---------------------------------------------------------------------------
module hex2sseg
   import sseg_mux_driver_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] sseg
);

   // Lookup of the classic hex glyphs; lowercase b and d keep them
   // distinguishable from 8 and 0 on a seven-segment digit.
   always_comb begin
      sseg = SSEG_BLANK;
      case (hex)
         4'h0: sseg = 7'h40;
         4'h1: sseg = 7'h79;
         4'h2: sseg = 7'h24;
         4'h3: sseg = 7'h30;
         4'h4: sseg = 7'h19;
         4'h5: sseg = 7'h12;
         4'h6: sseg = 7'h02;
         4'h7: sseg = 7'h78;
         4'h8: sseg = 7'h00;
         4'h9: sseg = 7'h10;
         4'hA: sseg = 7'h08;
         4'hB: sseg = 7'h03;
         4'hC: sseg = 7'h46;
         4'hD: sseg = 7'h21;
         4'hE: sseg = 7'h06;
         4'hF: sseg = 7'h0E;
         default: sseg = SSEG_BLANK;
      endcase
   end

endmodule

// File: rtl/sseg_mux_driver.sv
// ---------------------------------------------------------------------------
// sseg_mux_driver
// Time-multiplexed N-digit seven-segment driver. Each digit gets a slot of
// DIGIT_TICKS clock cycles; one digit is lit at a time from a shared segment
// bus. New values are staged in a shadow register and copied to the display
// register only at a frame boundary, so a scanned frame is never torn.
// Supports per-digit decimal point and blanking, leading-zero suppression
// and a 16-step brightness PWM inside each slot.
//
// Ports:
//   clk          in   1           system clock
//   reset        in   1           synchronous active-high reset
//   load         in   1           strobe: capture hex_in/dp_in/blank_in
//   hex_in       in   4*N_DIGITS  digit i nibble at [4i+3:4i], digit 0 rightmost
//   dp_in        in   N_DIGITS    decimal point request per digit
//   blank_in     in   N_DIGITS    1 = digit dark for its whole slot
//   lz_suppress  in   1           leading-zero suppression enable (live)
//   brightness   in   4           0 = 1/16 duty .. 15 = full duty (live)
//   AN           out  N_DIGITS    digit anodes, active low
//   sseg         out  7           segments {g..a}, active low
//   DP           out  1           decimal point, active low
//   frame_tick   out  1           pulse in the cycle after the scan wraps
// ---------------------------------------------------------------------------
module sseg_mux_driver
   import sseg_mux_driver_pkg::*;
#(
   parameter int N_DIGITS    = 8,
   parameter int DIGIT_TICKS = 100000,
   parameter int CNT_W       = 17
)
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [4*N_DIGITS-1:0] hex_in,
   input  logic [N_DIGITS-1:0]   dp_in,
   input  logic [N_DIGITS-1:0]   blank_in,
   input  logic                  lz_suppress,
   input  logic [3:0]            brightness,
   output logic [N_DIGITS-1:0]   AN,
   output logic [6:0]            sseg,
   output logic                  DP,
   output logic                  frame_tick
);

   localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(DIGIT_TICKS - 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_DIGITS - 1);
   localparam logic [CNT_W:0]   PWM_STEP  = (CNT_W+1)'(DIGIT_TICKS / PWM_LEVELS);

   // Reject parameter sets the scan and PWM arithmetic cannot support.
   generate
      if (N_DIGITS < 2 || N_DIGITS > 8) begin : g_bad_digits
         $error("sseg_mux_driver: N_DIGITS must be in 2..8");
      end
      if (DIGIT_TICKS < PWM_LEVELS || (DIGIT_TICKS % PWM_LEVELS) != 0) begin : g_bad_ticks
         $error("sseg_mux_driver: DIGIT_TICKS must be a multiple of 16 and at least 16");
      end
      if ((64'(1) << CNT_W) < 64'(DIGIT_TICKS)) begin : g_bad_cnt_w
         $error("sseg_mux_driver: CNT_W too narrow for DIGIT_TICKS");
      end
   endgenerate

   logic [CNT_W-1:0]      tick_cnt;
   logic [IDX_W-1:0]      digit_idx;
   logic                  boundary;

   logic                  pending;
   logic [4*N_DIGITS-1:0] shadow_hex;
   logic [N_DIGITS-1:0]   shadow_dp;
   logic [N_DIGITS-1:0]   shadow_blank;
   logic [4*N_DIGITS-1:0] disp_hex;
   logic [N_DIGITS-1:0]   disp_dp;
   logic [N_DIGITS-1:0]   disp_blank;

   logic [N_DIGITS-1:0]   suppress;
   logic                  dark_above;

   logic [3:0]            sel_hex;
   logic [6:0]            dec_sseg;
   logic [CNT_W:0]        on_limit;
   logic                  in_window;
   out_mode_e             out_mode;
   logic [N_DIGITS-1:0]   an_next;
   logic [6:0]            sseg_next;
   logic                  dp_next;

   assign boundary = (tick_cnt == LAST_TICK) && (digit_idx == LAST_IDX);

   // Slot timer and scan position. The counter runs through one slot, and
   // each time it wraps the scan moves to the next digit, wrapping back to
   // digit 0 after the leftmost one.
   always_ff @(posedge clk) begin
      if (reset) begin
         tick_cnt  <= '0;
         digit_idx <= '0;
      end else if (tick_cnt == LAST_TICK) begin
         tick_cnt  <= '0;
         digit_idx <= (digit_idx == LAST_IDX) ? '0 : digit_idx + IDX_W'(1);
      end else begin
         tick_cnt  <= tick_cnt + CNT_W'(1);
      end
   end

   // Frame pulse, registered so it lands in the first cycle of the new frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= boundary;
      end
   end

   // Double-buffered display values. A load always lands in the shadow and
   // marks it pending; the display picks up the shadow only at a frame
   // boundary. A load that coincides with the boundary wins the pending flag,
   // so the display takes the previous shadow now and the fresh values wait
   // one more frame instead of being dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         pending      <= 1'b0;
         shadow_hex   <= '0;
         shadow_dp    <= '0;
         shadow_blank <= '1;
         disp_hex     <= '0;
         disp_dp      <= '0;
         disp_blank   <= '1;
      end else begin
         if (boundary && pending) begin
            disp_hex   <= shadow_hex;
            disp_dp    <= shadow_dp;
            disp_blank <= shadow_blank;
         end
         if (load) begin
            shadow_hex   <= hex_in;
            shadow_dp    <= dp_in;
            shadow_blank <= blank_in;
            pending      <= 1'b1;
         end else if (boundary) begin
            pending      <= 1'b0;
         end
      end
   end

   // Leading-zero mask, walked from the most significant digit down. A zero
   // digit is hidden only while everything to its left is dark (hidden or
   // blanked); a lit digit or a zero carrying a decimal point stops the walk.
   // Digit 0 is never visited so a value of zero still shows a single "0".
   always_comb begin
      suppress   = '0;
      dark_above = 1'b1;
      for (int i = N_DIGITS - 1; i >= 1; i--) begin
         if (lz_suppress && (disp_hex[4*i +: 4] == 4'h0) && !disp_dp[i] && dark_above) begin
            suppress[i] = 1'b1;
         end
         dark_above = dark_above && (suppress[i] || disp_blank[i]);
      end
   end

   assign sel_hex = disp_hex[{digit_idx, 2'b00} +: 4];

   hex2sseg u_hex2sseg (
      .hex  (sel_hex),
      .sseg (dec_sseg)
   );

   // Brightness window: the digit is driven for the first (brightness+1)
   // sixteenths of its slot and dark for the remainder.
   assign on_limit  = ((CNT_W+1)'(brightness) + (CNT_W+1)'(1)) * PWM_STEP;
   assign in_window = ({1'b0, tick_cnt} < on_limit);

   // Decide whether this cycle lights the scanned digit and form the next
   // output pattern. When dark everything is held at its inactive level so
   // no ghosting shows on the shared segment bus.
   always_comb begin
      out_mode  = OUT_DARK;
      an_next   = '1;
      sseg_next = SSEG_BLANK;
      dp_next   = 1'b1;
      if (in_window && !disp_blank[digit_idx] && !suppress[digit_idx]) begin
         out_mode = OUT_LIT;
      end
      case (out_mode)
         OUT_LIT: begin
            an_next   = ~(N_DIGITS'(1) << digit_idx);
            sseg_next = dec_sseg;
            dp_next   = ~disp_dp[digit_idx];
         end
         default: begin
            an_next   = '1;
            sseg_next = SSEG_BLANK;
            dp_next   = 1'b1;
         end
      endcase
   end

   // Output register so the pins change cleanly, one cycle behind the scan.
   always_ff @(posedge clk) begin
      if (reset) begin
         AN   <= '1;
         sseg <= SSEG_BLANK;
         DP   <= 1'b1;
      end else begin
         AN   <= an_next;
         sseg <= sseg_next;
         DP   <= dp_next;
      end
   end

endmodule

// File: tb/tb_sseg_mux_driver.sv
// ---------------------------------------------------------------------------
// tb_sseg_mux_driver
// Self-checking bench for sseg_mux_driver with N_DIGITS=4, DIGIT_TICKS=16.
// A table of display settings is loaded one at a time; after the frame
// boundary that applies each load, the outputs are sampled at a chosen
// slot/offset and compared with hand-derived values. Hand-written sequences
// cover idle after reset, a load in the boundary cycle, back-to-back loads
// and reset in the middle of a scan.
// ---------------------------------------------------------------------------
module tb_sseg_mux_driver;

   localparam int N_DIGITS    = 4;
   localparam int DIGIT_TICKS = 16;
   localparam int CNT_W       = 5;
   localparam int FRAME       = N_DIGITS * DIGIT_TICKS;

   logic        clk = 1'b0;
   logic        reset;
   logic        load;
   logic [15:0] hex_in;
   logic [3:0]  dp_in;
   logic [3:0]  blank_in;
   logic        lz_suppress;
   logic [3:0]  brightness;
   logic [3:0]  AN;
   logic [6:0]  sseg;
   logic        DP;
   logic        frame_tick;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string       name;
      logic [15:0] hex;
      logic [3:0]  dp;
      logic [3:0]  blank;
      logic        lz;
      logic [3:0]  bright;
      int          slot;
      int          offset;
      logic [3:0]  exp_an;
      logic [6:0]  exp_sseg;
      logic        exp_dp;
   } vec_t;

   vec_t vecs[$];

   sseg_mux_driver #(
      .N_DIGITS    (N_DIGITS),
      .DIGIT_TICKS (DIGIT_TICKS),
      .CNT_W       (CNT_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .load        (load),
      .hex_in      (hex_in),
      .dp_in       (dp_in),
      .blank_in    (blank_in),
      .lz_suppress (lz_suppress),
      .brightness  (brightness),
      .AN          (AN),
      .sseg        (sseg),
      .DP          (DP),
      .frame_tick  (frame_tick)
   );

   // 100 MHz-style free-running clock.
   always #5 clk = ~clk;

   // Advance n rising edges and settle 1 time unit past the last one.
   task automatic stepCycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Single comparison with bookkeeping.
   task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   // Compare the three display outputs against an expected pattern.
   task automatic checkOutput(input string name, input logic [3:0] exp_an,
                              input logic [6:0] exp_sseg, input logic exp_dp);
      checkValue({name, "_AN"},   32'(AN),   32'(exp_an));
      checkValue({name, "_sseg"}, 32'(sseg), 32'(exp_sseg));
      checkValue({name, "_DP"},   32'(DP),   32'(exp_dp));
   endtask

   // Step until frame_tick is seen (at least one step), bounded.
   task automatic waitFrame(output int cycles);
      cycles = 0;
      do begin
         stepCycles(1);
         cycles++;
      end while (frame_tick !== 1'b1 && cycles < 3 * FRAME);
      checkValue("frame_seen", 32'(frame_tick), 32'(1));
   endtask

   // Load one vector's settings at the start of a frame, wait for the
   // boundary that applies them, then move to the requested slot/offset.
   task automatic applyStimulus(input vec_t v);
      int cyc;
      lz_suppress = v.lz;
      brightness  = v.bright;
      waitFrame(cyc);
      hex_in   = v.hex;
      dp_in    = v.dp;
      blank_in = v.blank;
      load     = 1'b1;
      stepCycles(1);
      load     = 1'b0;
      waitFrame(cyc);
      stepCycles(1 + v.slot * DIGIT_TICKS + v.offset);
   endtask

   task automatic addVec(input string name, input logic [15:0] hex, input logic [3:0] dp,
                         input logic [3:0] blank, input logic lz, input logic [3:0] bright,
                         input int slot, input int offset, input logic [3:0] exp_an,
                         input logic [6:0] exp_sseg, input logic exp_dp);
      vec_t v;
      v.name = name; v.hex = hex; v.dp = dp; v.blank = blank; v.lz = lz;
      v.bright = bright; v.slot = slot; v.offset = offset;
      v.exp_an = exp_an; v.exp_sseg = exp_sseg; v.exp_dp = exp_dp;
      vecs.push_back(v);
   endtask

   initial begin
      int cyc;
      int dark_errs;
      int ft_errs;
      int ft_count;

      // Glyphs: 0=40 1=79 2=24 3=30 4=19 5=12 A=08 B=03, dark=7F
      addVec("h1234_d0",   16'h1234, 4'b0000, 4'b0000, 1'b0, 4'd15, 0, 5,  4'b1110, 7'h19, 1'b1);
      addVec("h1234_d1",   16'h1234, 4'b0000, 4'b0000, 1'b0, 4'd15, 1, 0,  4'b1101, 7'h30, 1'b1);
      addVec("h1234_d2",   16'h1234, 4'b0000, 4'b0000, 1'b0, 4'd15, 2, 15, 4'b1011, 7'h24, 1'b1);
      addVec("h1234_d3",   16'h1234, 4'b0000, 4'b0000, 1'b0, 4'd15, 3, 8,  4'b0111, 7'h79, 1'b1);
      addVec("lz50_d3",    16'h0050, 4'b0000, 4'b0000, 1'b1, 4'd15, 3, 4,  4'b1111, 7'h7F, 1'b1);
      addVec("lz50_d2",    16'h0050, 4'b0000, 4'b0000, 1'b1, 4'd15, 2, 4,  4'b1111, 7'h7F, 1'b1);
      addVec("lz50_d1",    16'h0050, 4'b0000, 4'b0000, 1'b1, 4'd15, 1, 4,  4'b1101, 7'h12, 1'b1);
      addVec("lz50_d0",    16'h0050, 4'b0000, 4'b0000, 1'b1, 4'd15, 0, 4,  4'b1110, 7'h40, 1'b1);
      addVec("lzdp_d2",    16'h0050, 4'b0100, 4'b0000, 1'b1, 4'd15, 2, 4,  4'b1011, 7'h40, 1'b0);
      addVec("lzdp_d3",    16'h0050, 4'b0100, 4'b0000, 1'b1, 4'd15, 3, 4,  4'b1111, 7'h7F, 1'b1);
      addVec("nolz_d3",    16'h0050, 4'b0000, 4'b0000, 1'b0, 4'd15, 3, 4,  4'b0111, 7'h40, 1'b1);
      addVec("pwm3_on",    16'h1234, 4'b0000, 4'b0000, 1'b0, 4'd3,  1, 3,  4'b1101, 7'h30, 1'b1);
      addVec("pwm3_off",   16'h1234, 4'b0000, 4'b0000, 1'b0, 4'd3,  1, 4,  4'b1111, 7'h7F, 1'b1);
      addVec("pwm0_on",    16'h1234, 4'b0000, 4'b0000, 1'b0, 4'd0,  2, 0,  4'b1011, 7'h24, 1'b1);
      addVec("pwm0_off",   16'h1234, 4'b0000, 4'b0000, 1'b0, 4'd0,  2, 1,  4'b1111, 7'h7F, 1'b1);
      addVec("blank_d1",   16'h1234, 4'b0000, 4'b0010, 1'b0, 4'd15, 1, 7,  4'b1111, 7'h7F, 1'b1);
      addVec("blank_d0ok", 16'h1234, 4'b0000, 4'b0010, 1'b0, 4'd15, 0, 7,  4'b1110, 7'h19, 1'b1);
      addVec("lzblk_d1",   16'h0005, 4'b0000, 4'b0100, 1'b1, 4'd15, 1, 2,  4'b1111, 7'h7F, 1'b1);
      addVec("lzblk_d0",   16'h0005, 4'b0000, 4'b0100, 1'b1, 4'd15, 0, 2,  4'b1110, 7'h12, 1'b1);
      addVec("lzlit_d1",   16'h1005, 4'b0000, 4'b0100, 1'b1, 4'd15, 1, 2,  4'b1101, 7'h40, 1'b1);
      addVec("lzzero_d0",  16'h0000, 4'b0000, 4'b0000, 1'b1, 4'd15, 0, 9,  4'b1110, 7'h40, 1'b1);
      addVec("lzzdp_d0",   16'h0000, 4'b0001, 4'b0000, 1'b1, 4'd15, 0, 9,  4'b1110, 7'h40, 1'b0);
      addVec("mid_d2",     16'h1234, 4'b0000, 4'b0000, 1'b0, 4'd15, 2, 5,  4'b1011, 7'h24, 1'b1);

      reset       = 1'b1;
      load        = 1'b0;
      hex_in      = '0;
      dp_in       = '0;
      blank_in    = '0;
      lz_suppress = 1'b0;
      brightness  = 4'd15;
      stepCycles(3);
      checkOutput("reset", 4'b1111, 7'h7F, 1'b1);
      checkValue("reset_frame_tick", 32'(frame_tick), 32'(0));

      // Idle after reset: dark throughout, frame pulse every 64 cycles.
      reset     = 1'b0;
      dark_errs = 0;
      ft_errs   = 0;
      ft_count  = 0;
      for (int k = 1; k <= 200; k++) begin
         stepCycles(1);
         if (AN !== 4'b1111 || sseg !== 7'h7F || DP !== 1'b1) dark_errs++;
         if (frame_tick !== ((k % FRAME) == 0)) ft_errs++;
         if (frame_tick === 1'b1) ft_count++;
      end
      checkValue("idle_dark_errs", 32'(dark_errs), 32'(0));
      checkValue("idle_ft_errs",   32'(ft_errs),   32'(0));
      checkValue("idle_ft_count",  32'(ft_count),  32'(3));

      // Table-driven vectors; the last leaves digit 2 lit for the reset test.
      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         checkOutput(vecs[i].name, vecs[i].exp_an, vecs[i].exp_sseg, vecs[i].exp_dp);
      end

      // Reset in the middle of digit 2's slot.
      reset = 1'b1;
      stepCycles(1);
      checkOutput("midrst", 4'b1111, 7'h7F, 1'b1);
      checkValue("midrst_frame_tick", 32'(frame_tick), 32'(0));
      reset = 1'b0;
      waitFrame(cyc);
      checkValue("midrst_frame_len", 32'(cyc), 32'(FRAME));
      stepCycles(1 + 2 * DIGIT_TICKS + 1);
      checkOutput("midrst_d2_dark", 4'b1111, 7'h7F, 1'b1);
      stepCycles(DIGIT_TICKS);
      checkOutput("midrst_d3_dark", 4'b1111, 7'h7F, 1'b1);

      // Load AAAA at frame start, then BBBB in the boundary cycle itself.
      brightness  = 4'd15;
      lz_suppress = 1'b0;
      dp_in       = '0;
      blank_in    = '0;
      waitFrame(cyc);
      hex_in = 16'hAAAA;
      load   = 1'b1;
      stepCycles(1);
      load   = 1'b0;
      stepCycles(FRAME - 2);
      hex_in = 16'hBBBB;
      load   = 1'b1;
      stepCycles(1);
      load   = 1'b0;
      checkValue("bnd_frame_tick", 32'(frame_tick), 32'(1));
      stepCycles(1);
      checkOutput("bnd_A_d0", 4'b1110, 7'h08, 1'b1);
      stepCycles(3 * DIGIT_TICKS + 2);
      checkOutput("bnd_A_d3", 4'b0111, 7'h08, 1'b1);
      waitFrame(cyc);
      stepCycles(1 + DIGIT_TICKS);
      checkOutput("bnd_B_d1", 4'b1101, 7'h03, 1'b1);

      // Back-to-back loads: the second one is what appears.
      waitFrame(cyc);
      hex_in = 16'h1111;
      load   = 1'b1;
      stepCycles(1);
      hex_in = 16'h2222;
      stepCycles(1);
      load   = 1'b0;
      waitFrame(cyc);
      stepCycles(1);
      checkOutput("b2b_d0", 4'b1110, 7'h24, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Absolute watchdog so the run always ends.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/sseg_mux_driver.md
Name: sseg_mux_driver

Overview:
Time-multiplexed N-digit seven-segment driver, successor to the static switch-driven display test. It scans all digits in turn from a single segment bus and uses the existing hex2sseg decoder. Per-digit features: hex value, decimal point and blanking. Global features: leading-zero suppression and 16-level brightness PWM. New display values are loaded into a shadow register and applied only at a frame boundary, so a frame never shows a mix of old and new values.

Parameters:
N_DIGITS, 8, number of digits scanned (2..8)
DIGIT_TICKS, 100000, clk cycles per digit slot (1 ms at 100 MHz); must be a multiple of 16 and at least 16
CNT_W, 17, tick counter width; must satisfy 2^CNT_W >= DIGIT_TICKS

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
load  in  1  one-cycle strobe; captures hex_in, dp_in and blank_in into the shadow register
hex_in  in  4*N_DIGITS  digit i value in bits [4i+3:4i]; digit 0 is rightmost / least significant
dp_in  in  N_DIGITS  decimal point request per digit, 1 = on
blank_in  in  N_DIGITS  1 = digit i dark for its whole slot
lz_suppress  in  1  1 = leading-zero suppression enabled (sampled live, every cycle)
brightness  in  4  0 = dimmest (1/16 duty), 15 = full duty (sampled live)
AN  out  N_DIGITS  digit anodes, active low
sseg  out  7  segments a..g, active low (hex2sseg output pattern)
DP  out  1  decimal point, active low
frame_tick  out  1  one-cycle pulse when the digit index wraps from N_DIGITS-1 to 0

Behaviour:
- Reset values:
  - AN all ones; sseg 7'h7F; DP 1; frame_tick 0.
  - Tick counter and digit index 0; pending 0.
  - Shadow and display registers: hex 0, dp 0, blank all ones. The display stays dark until the first load followed by a frame boundary.
- Tick counter: counts 0..DIGIT_TICKS-1 and wraps. When it equals DIGIT_TICKS-1, the digit index advances, wrapping N_DIGITS-1 -> 0.
- Boundary cycle: the cycle where the counter is DIGIT_TICKS-1 and the index is N_DIGITS-1. frame_tick is registered and is high exactly in the cycle after the boundary cycle.
- Load:
  - load=1 writes the inputs into shadow on the next edge and sets pending.
  - At the boundary, if pending=1, display <= shadow and pending clears.
  - If load is asserted in the boundary cycle itself: display takes the old shadow, the new inputs enter shadow, and pending stays 1, so the new values apply at the next boundary.
  - Back-to-back loads: the last one wins.
- Leading-zero suppression (combinational over the display register):
  - Digit i is suppressed when lz_suppress=1, i>0, hex[i]==0, dp[i]==0, and every digit j>i is either suppressed or blanked.
  - Digit 0 is never suppressed.
  - A digit with its dp bit set ends suppression and is shown as "0.".
- PWM on-window: counter < (brightness+1)*(DIGIT_TICKS/16). Outside the window AN is all ones, and sseg/DP are don't-care but driven 7'h7F/1.
- Per-cycle output, registered (1-cycle latency from counter/index):
  - Digit is active when inside the on-window and not blanked and not suppressed.
  - Active: AN = all ones except bit[index]=0; sseg = hex2sseg(display hex[index]); DP = ~dp[index].
  - Inactive: AN all ones, sseg 7'h7F, DP 1.
- Reset mid-scan: everything returns to reset values on the next edge, and the shadow contents are lost.

Decomposition:
- Shared package: none needed; parameter checks via generate-time assertions.
- Sub-module: hex2sseg (existing, instantiated once on the selected nibble).
- Optional internal split: sseg_lz_mask (combinational suppression mask); keep inline unless reused.

Test Plan:
All scenarios use N_DIGITS=4, DIGIT_TICKS=16.
- Reset then idle 200 cycles -> AN=4'b1111, sseg=7'h7F, DP=1 throughout; frame_tick pulses every 64 cycles.
- load hex=16'h1234, dp=0, blank=0, brightness=15 -> after the next boundary, AN cycles 1110,1101,1011,0111 in 16-cycle slots with sseg=hex2sseg(4,3,2,1) respectively, 1 cycle after each index change.
- hex=16'h0050, lz_suppress=1 -> digits 3 and 2 dark, digit 1 shows 5, digit 0 shows 0. Then dp_in=4'b0100 loaded -> digit 2 shows "0." and digit 3 stays dark.
- brightness=3 -> within each slot AN is low for exactly 4 cycles (counter 0..3) and all ones for 12 cycles.
- load 16'hAAAA, then load 16'hBBBB in the boundary cycle -> the next frame shows A on all digits, the frame after shows B.
- reset asserted mid-slot with digit 2 active -> next edge AN=4'b1111 and index 0; shown values cleared until a new load plus boundary.
